// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with input FIFO and back-to-back framing
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   data       in   [DATA_BITS] word to transmit, captured on the push edge
//   data_ready in   write strobe; pushes data when full=0
//   full       out  FIFO holds FIFO_DEPTH words
//   busy       out  frame in progress or FIFO non-empty
//   done       out  one-cycle pulse after each frame's last stop bit
//   overflow   out  one-cycle pulse after a push attempted while full
//   serial     out  TX line, idle high
module uart_tx_fifo #(
    parameter int CLK_PER_BIT = 100,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 data_ready,
    output logic                 full,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic                 serial
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(CLK_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 serial_q, serial_d;
    logic                 done_q, done_d;
    logic                 overflow_q, overflow_d;
    logic                 push, pop, bit_end, full_now;

    assign full_now = (count_q == CW'(FIFO_DEPTH));
    assign full     = full_now;
    assign busy     = (state_q != S_IDLE) || (count_q != '0);
    assign done     = done_q;
    assign overflow = overflow_q;
    assign serial   = serial_q;

    always_comb begin
        push       = data_ready && !full_now;
        overflow_d = data_ready && full_now;
        bit_end    = (timer_q == TW'(CLK_PER_BIT - 1));
        pop        = 1'b0;
        done_d     = 1'b0;
        state_d    = state_q;
        timer_d    = bit_end ? '0 : timer_q + TW'(1);
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        par_d      = par_q;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    idx_d   = '0;
                end
            end
            S_STOP: begin
                // idx_q counts stop bits here so STOP_BITS=2 reuses the bit timer
                if (bit_end) begin
                    if (idx_q == IW'(STOP_BITS - 1)) begin
                        done_d = 1'b1;
                        idx_d  = '0;
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Parity is fixed at pop time from the latched word
        if (pop) begin
            shreg_d = mem_q[rd_ptr_q];
            par_d   = (^mem_q[rd_ptr_q]) ^ (PARITY == 1);
        end

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);

        // serial is registered, so it reflects the state being entered
        case (state_d)
            S_START: serial_d = 1'b0;
            S_DATA:  serial_d = shreg_d[0];
            S_PAR:   serial_d = par_d;
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            timer_q    <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            serial_q   <= 1'b1;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            serial_q   <= serial_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
